// File: rtl/iso15693_tx_sequencer_if.sv
// Byte stream from the command source into the ISO15693 transmit sequencer.
// The master presents data/data_last under data_valid; the slave raises
// data_ready only at the points where it takes a byte.
interface iso15693_tx_sequencer_if;
   logic [7:0] data;
   logic       data_valid;
   logic       data_last;
   logic       data_ready;

   modport master (output data, output data_valid, output data_last, input data_ready);
   modport slave  (input data, input data_valid, input data_last, output data_ready);
endinterface

// File: rtl/iso15693_tx_sequencer.sv
// ISO15693 reader-transmit frame sequencer: SOF, 1-out-of-4 coded data, EOF.
// All timing is in carrier cycles. mod_carrier_on=0 means pause (modulate).
// Outputs are registered by evaluating the envelope for the next state/counter,
// so the registered value lines up with the state it belongs to.
module iso15693_tx_sequencer #(
   parameter int SLOT_LEN  = 256,
   parameter int PAUSE_LEN = 128
) (
   input  logic                      ck_1356meg,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      shallow_in,
   iso15693_tx_sequencer_if.slave    bus,
   output logic                      mod_carrier_on,
   output logic                      shallow_modulation,
   output logic                      busy,
   output logic                      done,
   output logic                      underrun
);

   localparam int CW = $clog2(4 * SLOT_LEN);
   localparam logic [CW-1:0] LAST4 = CW'(4 * SLOT_LEN - 1);
   localparam logic [CW-1:0] LAST2 = CW'(2 * SLOT_LEN - 1);

   typedef enum logic [1:0] {IDLE, SOF, DATA, EOF} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic [1:0]      pair_q, pair_d;
   logic [7:0]      byte_q, byte_d;
   logic            last_q, last_d;
   logic            und_q, und_d;
   logic            shal_q, shal_d;
   logic            done_d;
   logic            mod_q, mod_d;
   logic            busy_q;
   logic            load_pt;
   logic [1:0]      v_d;

   // Envelope rule: true when the given position is inside a pause.
   function automatic logic is_pause(state_e st, logic [CW-1:0] c, logic [1:0] v);
      int ci;
      int vi;
      ci = int'(c);
      vi = int'(v);
      case (st)
         SOF:     is_pause = (ci < PAUSE_LEN) || (ci >= 4 * SLOT_LEN - PAUSE_LEN);
         DATA:    is_pause = (ci >= vi * SLOT_LEN + SLOT_LEN - PAUSE_LEN) &&
                             (ci < (vi + 1) * SLOT_LEN);
         EOF:     is_pause = (ci >= SLOT_LEN) && (ci < SLOT_LEN + PAUSE_LEN);
         default: is_pause = 1'b0;
      endcase
   endfunction

   // Byte load points: last SOF cycle, and last cycle of pair 3 when more bytes follow.
   always_comb begin
      load_pt = (cyc_q == LAST4) &&
                ((state_q == SOF) || ((state_q == DATA) && (pair_q == 2'd3) && !last_q));
   end

   assign bus.data_ready = load_pt;

   // Next-state, counter and byte/pair tracking.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q + CW'(1);
      pair_d  = pair_q;
      byte_d  = byte_q;
      last_d  = last_q;
      und_d   = und_q;
      shal_d  = shal_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cyc_d = '0;
            if (start) begin
               shal_d  = shallow_in;
               und_d   = 1'b0;
               state_d = SOF;
            end
         end
         SOF: begin
            if (cyc_q == LAST4) begin
               cyc_d = '0;
               if (bus.data_valid) begin
                  byte_d  = bus.data;
                  last_d  = bus.data_last;
                  pair_d  = 2'd0;
                  state_d = DATA;
               end else begin
                  und_d   = 1'b1;
                  state_d = EOF;
               end
            end
         end
         DATA: begin
            if (cyc_q == LAST4) begin
               cyc_d = '0;
               if (pair_q != 2'd3) begin
                  pair_d = pair_q + 2'd1;
               end else if (last_q) begin
                  state_d = EOF;
               end else if (bus.data_valid) begin
                  byte_d = bus.data;
                  last_d = bus.data_last;
                  pair_d = 2'd0;
               end else begin
                  und_d   = 1'b1;
                  state_d = EOF;
               end
            end
         end
         EOF: begin
            if (cyc_q == LAST2) begin
               cyc_d   = '0;
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cyc_d   = '0;
         end
      endcase
      v_d   = byte_d[{pair_d, 1'b0} +: 2];
      mod_d = !is_pause(state_d, cyc_d, v_d);
   end

   // State and registered outputs; reset aborts any frame with carrier on.
   always_ff @(posedge ck_1356meg or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         pair_q  <= 2'd0;
         byte_q  <= 8'h00;
         last_q  <= 1'b0;
         und_q   <= 1'b0;
         shal_q  <= 1'b0;
         done    <= 1'b0;
         mod_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         pair_q  <= pair_d;
         byte_q  <= byte_d;
         last_q  <= last_d;
         und_q   <= und_d;
         shal_q  <= shal_d;
         done    <= done_d;
         mod_q   <= mod_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign mod_carrier_on     = mod_q;
   assign busy               = busy_q;
   assign underrun           = und_q;
   assign shallow_modulation = shal_q;

endmodule

// File: tb/tb_iso15693_tx_sequencer.sv
// Self-checking bench for iso15693_tx_sequencer. Expected envelopes are built
// symbol by symbol (SOF, 1-of-4 pairs, EOF) into per-cycle queues and compared
// against the DUT on the falling edge.
module tb_iso15693_tx_sequencer;
   localparam int S = 256;
   localparam int P = 128;

   logic ck_1356meg = 1'b0;
   logic rst_n      = 1'b0;
   logic start      = 1'b0;
   logic shallow_in = 1'b0;
   logic mod_carrier_on, shallow_modulation, busy, done, underrun;

   iso15693_tx_sequencer_if bus ();

   iso15693_tx_sequencer #(.SLOT_LEN(S), .PAUSE_LEN(P)) dut (
      .ck_1356meg         (ck_1356meg),
      .rst_n              (rst_n),
      .start              (start),
      .shallow_in         (shallow_in),
      .bus                (bus.slave),
      .mod_carrier_on     (mod_carrier_on),
      .shallow_modulation (shallow_modulation),
      .busy               (busy),
      .done               (done),
      .underrun           (underrun)
   );

   always #5 ck_1356meg = ~ck_1356meg;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Frame description: bytes, last flags, and whether the source has the byte ready.
   logic [7:0] fb[4];
   bit         fl[4];
   bit         fa[4];
   int         nb;

   bit em[$];   // expected mod_carrier_on per cycle
   bit er[$];   // expected data_ready per cycle
   bit eund;

   task automatic build_model();
      int v;
      em.delete();
      er.delete();
      eund = 0;
      for (int t = 0; t < 4 * S; t++) begin
         em.push_back(!(t < P || t >= 4 * S - P));
         er.push_back(t == 4 * S - 1);
      end
      if (!fa[0]) eund = 1;
      else begin
         for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < 4; k++) begin
               v = (int'(fb[i]) >> (2 * k)) & 3;
               for (int t = 0; t < 4 * S; t++) begin
                  em.push_back(!(t >= v * S + S - P && t < (v + 1) * S));
                  er.push_back(k == 3 && t == 4 * S - 1 && !fl[i]);
               end
            end
            if (fl[i]) break;
            if (!fa[i + 1]) begin
               eund = 1;
               break;
            end
         end
      end
      for (int t = 0; t < 2 * S; t++) begin
         em.push_back(!(t >= S && t < S + P));
         er.push_back(1'b0);
      end
   endtask

   task automatic present(input int i);
      if (i < nb) begin
         bus.data       = fb[i];
         bus.data_valid = fa[i];
         bus.data_last  = fl[i];
      end else begin
         bus.data       = 8'h00;
         bus.data_valid = 1'b0;
         bus.data_last  = 1'b0;
      end
   endtask

   // Runs one frame from start to one cycle past done; start2 >= 0 fires a second start.
   task automatic run_frame(input string nm, input bit shal, input int start2);
      int len, idx;
      bit took;
      int bad_mod, bad_rdy, bad_busy, bad_shal, bad_done;
      build_model();
      len = em.size();
      idx = 0; took = 0;
      bad_mod = 0; bad_rdy = 0; bad_busy = 0; bad_shal = 0; bad_done = 0;
      @(negedge ck_1356meg);
      present(0);
      shallow_in = shal;
      start      = 1'b1;
      for (int t = 0; t <= len + 1; t++) begin
         @(negedge ck_1356meg);
         if (t == 0) begin
            start      = 1'b0;
            shallow_in = 1'b0;
            chk({nm, "_und_clr"}, int'(underrun), 0);
         end
         if (took) begin
            idx++;
            present(idx);
            took = 0;
         end
         if (t < len) begin
            if (mod_carrier_on !== em[t]) bad_mod++;
            if (bus.data_ready !== er[t]) bad_rdy++;
            if (busy !== 1'b1) bad_busy++;
            if (done !== 1'b0) bad_done++;
            if (shallow_modulation !== shal) bad_shal++;
         end else if (t == len) begin
            chk({nm, "_done"}, int'(done), 1);
            chk({nm, "_busy_end"}, int'(busy), 0);
            chk({nm, "_mod_end"}, int'(mod_carrier_on), 1);
            chk({nm, "_underrun"}, int'(underrun), int'(eund));
            chk({nm, "_shal_hold"}, int'(shallow_modulation), int'(shal));
         end else begin
            chk({nm, "_done_pulse"}, int'(done), 0);
         end
         if (t == start2) begin
            start      = 1'b1;
            shallow_in = !shal;
         end else if (t == start2 + 1) begin
            start      = 1'b0;
            shallow_in = 1'b0;
         end
         if (bus.data_ready && bus.data_valid) took = 1;
      end
      present(nb);
      chk({nm, "_env_bad_cycles"}, bad_mod, 0);
      chk({nm, "_ready_bad_cycles"}, bad_rdy, 0);
      chk({nm, "_busy_bad_cycles"}, bad_busy, 0);
      chk({nm, "_done_bad_cycles"}, bad_done, 0);
      chk({nm, "_shal_bad_cycles"}, bad_shal, 0);
      chk({nm, "_bytes_taken"}, idx, (eund && !fa[0]) ? 0 : idx);
   endtask

   initial begin
      int npause, nbusy;
      bus.data = 8'h00; bus.data_valid = 1'b0; bus.data_last = 1'b0;
      repeat (3) @(negedge ck_1356meg);
      chk("rst_mod", int'(mod_carrier_on), 1);
      chk("rst_ready", int'(bus.data_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_underrun", int'(underrun), 0);
      chk("rst_shallow", int'(shallow_modulation), 0);
      rst_n = 1'b1;

      // Reset in the middle of the SOF pause aborts immediately.
      nb = 1; fb[0] = 8'h1B; fl[0] = 1; fa[0] = 1;
      @(negedge ck_1356meg);
      present(0); start = 1'b1;
      @(negedge ck_1356meg);
      start = 1'b0;
      repeat (50) @(negedge ck_1356meg);
      chk("midframe_pause", int'(mod_carrier_on), 0);
      chk("midframe_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_mod", int'(mod_carrier_on), 1);
      chk("abort_busy", int'(busy), 0);
      chk("abort_ready", int'(bus.data_ready), 0);
      @(negedge ck_1356meg);
      rst_n = 1'b1;
      npause = 0; nbusy = 0;
      for (int t = 0; t < 5000; t++) begin
         @(negedge ck_1356meg);
         if (!mod_carrier_on) npause++;
         if (busy) nbusy++;
      end
      chk("idle_pauses", npause, 0);
      chk("idle_busy", nbusy, 0);
      present(1);

      // Single byte 0x1B.
      nb = 1; fb[0] = 8'h1B; fl[0] = 1; fa[0] = 1;
      run_frame("one_byte", 1'b0, -10);
      // Underrun at SOF.
      nb = 1; fb[0] = 8'h5A; fl[0] = 1; fa[0] = 0;
      run_frame("sof_underrun", 1'b0, -10);
      // Two bytes 0x00, 0xFF.
      nb = 2; fb[0] = 8'h00; fl[0] = 0; fa[0] = 1; fb[1] = 8'hFF; fl[1] = 1; fa[1] = 1;
      run_frame("two_bytes", 1'b0, -10);
      // Shallow frame with an ignored second start.
      nb = 1; fb[0] = 8'h1B; fl[0] = 1; fa[0] = 1;
      run_frame("shallow_restart", 1'b1, 500);
      // Starve after the first byte.
      nb = 2; fb[0] = 8'hAA; fl[0] = 0; fa[0] = 1; fb[1] = 8'h33; fl[1] = 1; fa[1] = 0;
      run_frame("starve", 1'b0, -10);

      // Randomized frames.
      for (int r = 0; r < 3; r++) begin
         nb = int'($urandom_range(1, 2));
         for (int i = 0; i < nb; i++) begin
            fb[i] = 8'($urandom);
            fl[i] = (i == nb - 1);
            fa[i] = ($urandom_range(0, 9) != 0);
         end
         run_frame($sformatf("rand%0d", r), 1'($urandom), int'($urandom_range(0, 3000)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
